aes_resp_model: RTL

- Cycle-accurate responder for the AES-side handshake (aes_ready / aes_start / pt_to_aes / ct_from_aes) driven by the comm block's control block.
- Replaces the real AES core during UART/control-path bring-up and SCA trigger-timing characterisation.
- Computes a cheap deterministic transform after a programmable latency and raises a scope trigger while busy.

---
 rtl/aes_if_pkg.sv | 21 ++
 rtl/aes_lat_counter.sv | 35 +++
 rtl/aes_resp_model.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/aes_if_pkg.sv
// Shared definitions for the AES-side handshake responder: block width,
// FSM state encodings, the default transform mask and the rotate helper.
package aes_if_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int LAT_W       = 8;

  localparam logic [AES_BLOCK_W-1:0] DEFAULT_KEY =
    128'h0f0e0d0c0b0a09080706050403020100;

  // FSM encodings kept as plain constants so older tools can consume them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Rotate a block left by one byte; the top byte wraps to the bottom.
  function automatic logic [AES_BLOCK_W-1:0] rotl8(input logic [AES_BLOCK_W-1:0] x);
    return {x[AES_BLOCK_W-9:0], x[AES_BLOCK_W-1:AES_BLOCK_W-8]};
  endfunction

endpackage

// File: rtl/aes_lat_counter.sv
// Loadable down-counter used to time the busy phase of one operation.
// The counter saturates at zero; zero is flagged from the registered value.
module aes_lat_counter
  import aes_if_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load takes priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/aes_resp_model.sv
// Stand-in for the AES core on the comm-block handshake. Accepts a block,
// stays busy for LATENCY cycles with the scope trigger raised, then presents
// rotl8(pt) ^ KEY with a one-cycle ct_valid pulse. Starts seen while busy are
// dropped and latch a sticky error flag.
module aes_resp_model
  import aes_if_pkg::*;
#(
  parameter int                     LATENCY = 11,
  parameter logic [AES_BLOCK_W-1:0] KEY     = DEFAULT_KEY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   aes_start,
  input  logic [AES_BLOCK_W-1:0] pt_to_aes,
  output logic                   aes_ready,
  output logic [AES_BLOCK_W-1:0] ct_from_aes,
  output logic                   ct_valid,
  output logic                   trigger,
  output logic                   busy_err
);

  // Counter starts at LATENCY-1 so the busy phase spans exactly LATENCY edges.
  localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LATENCY - 1);

  logic [1:0]             state_r;
  logic [1:0]             state_nx_s;
  logic [AES_BLOCK_W-1:0] pt_r;
  logic [AES_BLOCK_W-1:0] ct_r;
  logic                   ct_valid_r;
  logic                   ready_r;
  logic                   trig_r;
  logic                   busy_err_r;

  logic                   start_ok_s;
  logic                   finish_s;
  logic                   start_in_busy_s;
  logic                   cnt_zero_s;
  logic [LAT_W-1:0]       cnt_s;

  // Busy-phase timer: loaded on accept, counts down while busy.
  aes_lat_counter #(
    .W (LAT_W)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (start_ok_s),
    .load_val (LOAD_VAL),
    .dec      (state_r == ST_BUSY),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // Handshake qualifiers: accept only when idle/done, finish when timer expires.
  always_comb begin
    start_ok_s      = 1'b0;
    finish_s        = 1'b0;
    start_in_busy_s = 1'b0;
    if (state_r == ST_BUSY) begin
      finish_s        = cnt_zero_s;
      start_in_busy_s = aes_start;
    end else begin
      start_ok_s      = aes_start;
    end
  end

  // Next-state decode; IDLE and DONE react identically to a start.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (aes_start) begin
          state_nx_s = ST_BUSY;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_zero_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (aes_start) begin
          state_nx_s = ST_BUSY;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register plus ready/trigger, registered from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      trig_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ready_r <= (state_nx_s != ST_BUSY);
      trig_r  <= (state_nx_s == ST_BUSY);
    end
  end

  // Plaintext capture on an accepted start; later pt changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pt_r <= {AES_BLOCK_W{1'b0}};
    end else if (start_ok_s) begin
      pt_r <= pt_to_aes;
    end else begin
      pt_r <= pt_r;
    end
  end

  // Result register and completion pulse; result holds until next finish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ct_r       <= {AES_BLOCK_W{1'b0}};
      ct_valid_r <= 1'b0;
    end else begin
      ct_valid_r <= finish_s;
      if (finish_s) begin
        ct_r <= rotl8(pt_r) ^ KEY;
      end else begin
        ct_r <= ct_r;
      end
    end
  end

  // Sticky protocol-error flag for starts issued while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_err_r <= 1'b0;
    end else if (start_in_busy_s) begin
      busy_err_r <= 1'b1;
    end else begin
      busy_err_r <= busy_err_r;
    end
  end

  assign aes_ready   = ready_r;
  assign ct_from_aes = ct_r;
  assign ct_valid    = ct_valid_r;
  assign trigger     = trig_r;
  assign busy_err    = busy_err_r;

endmodule
